// File: rtl/io_input_sync.sv
// Four-port memory-mapped input block: 2-flop synchronizers, whole-word
// debounce, per-port change flags cleared on status read, and a level IRQ.
module io_input_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        read_io_enable,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    input  logic [31:0] in_port3,
    output logic [31:0] io_read_data,
    output logic        io_irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [5:0] ADDR_PORT0  = 6'b110000;
    localparam logic [5:0] ADDR_PORT1  = 6'b110001;
    localparam logic [5:0] ADDR_PORT2  = 6'b110010;
    localparam logic [5:0] ADDR_PORT3  = 6'b110011;
    localparam logic [5:0] ADDR_STATUS = 6'b110100;

    logic [3:0][31:0] in_bus;
    logic [3:0][31:0] stable_bus;
    logic [3:0]       chg_set;
    logic [3:0]       chg_reg;
    logic [3:0]       chg_next;
    logic [31:0]      read_data_reg;
    logic [31:0]      sel_data;
    logic             irq_reg;
    logic             read_clear;
    logic             addr_unused;

    assign in_bus[0] = in_port0;
    assign in_bus[1] = in_port1;
    assign in_bus[2] = in_port2;
    assign in_bus[3] = in_port3;

    // Only the word offset within the block is decoded.
    assign addr_unused = ^{addr[31:8], addr[1:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            logic [31:0]      sync1_reg;
            logic [31:0]      sync2_reg;
            logic [31:0]      cand_reg;
            logic [31:0]      stable_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge io_clk) begin
                if (reset) begin
                    sync1_reg  <= '0;
                    sync2_reg  <= '0;
                    cand_reg   <= '0;
                    stable_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= in_bus[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != cand_reg) begin
                        cand_reg <= sync2_reg;
                        cnt_reg  <= '0;
                    end else if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end else if (stable_reg != cand_reg) begin
                        // Counter stays saturated; a later mismatch reloads it.
                        stable_reg <= cand_reg;
                    end
                end
            end

            assign chg_set[gi]    = (sync2_reg == cand_reg) && (cnt_reg == CNT_LAST) &&
                                    (stable_reg != cand_reg);
            assign stable_bus[gi] = stable_reg;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        case (addr[7:2])
            ADDR_PORT0:  sel_data = stable_bus[0];
            ADDR_PORT1:  sel_data = stable_bus[1];
            ADDR_PORT2:  sel_data = stable_bus[2];
            ADDR_PORT3:  sel_data = stable_bus[3];
            ADDR_STATUS: sel_data = {28'b0, chg_reg};
            default:     sel_data = '0;
        endcase
    end

    assign read_clear = read_io_enable && (addr[7:2] == ADDR_STATUS);
    // A new acceptance wins over a clearing read in the same cycle.
    assign chg_next   = (chg_reg & ~{4{read_clear}}) | chg_set;

    always_ff @(posedge io_clk) begin
        if (reset) begin
            chg_reg       <= '0;
            read_data_reg <= '0;
            irq_reg       <= 1'b0;
        end else begin
            chg_reg <= chg_next;
            irq_reg <= |chg_reg;
            if (read_io_enable) begin
                read_data_reg <= sel_data;
            end
        end
    end

    assign io_read_data = read_data_reg;
    assign io_irq       = irq_reg;

endmodule

// File: tb/tb_io_input_sync.sv
// Bench for io_input_sync: directed scenarios then random traffic, every
// cycle compared against a run-length reference model of the port rules.
module tb_io_input_sync;

    localparam int D = 4;

    logic        io_clk = 1'b0;
    logic        reset;
    logic        read_io_enable;
    logic [31:0] addr;
    logic [31:0] in_port0, in_port1, in_port2, in_port3;
    logic [31:0] io_read_data;
    logic        io_irq;

    logic [31:0] drv [4];

    assign in_port0 = drv[0];
    assign in_port1 = drv[1];
    assign in_port2 = drv[2];
    assign in_port3 = drv[3];

    always #5 io_clk = ~io_clk;

    io_input_sync #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .io_clk         (io_clk),
        .reset          (reset),
        .addr           (addr),
        .read_io_enable (read_io_enable),
        .in_port0       (in_port0),
        .in_port1       (in_port1),
        .in_port2       (in_port2),
        .in_port3       (in_port3),
        .io_read_data   (io_read_data),
        .io_irq         (io_irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: two-sample delay line, then a run length of identical
    // synchronized samples; a value is accepted once it has been seen D+1 times.
    logic [31:0] m_d1 [4];
    logic [31:0] m_d2 [4];
    logic [31:0] m_prev [4];
    int          m_run [4];
    logic [31:0] m_stable [4];
    logic [3:0]  m_chg;
    logic [31:0] m_rd;
    logic        m_irq;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic re, input logic [31:0] a);
        logic [31:0] sel;
        logic [3:0]  set;
        logic        clr;
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                m_d1[n] = '0; m_d2[n] = '0; m_prev[n] = '0;
                m_run[n] = 1; m_stable[n] = '0;
            end
            m_chg = '0; m_rd = '0; m_irq = 1'b0;
        end else begin
            case (a[7:2])
                6'h30:   sel = m_stable[0];
                6'h31:   sel = m_stable[1];
                6'h32:   sel = m_stable[2];
                6'h33:   sel = m_stable[3];
                6'h34:   sel = {28'b0, m_chg};
                default: sel = '0;
            endcase
            clr = re && (a[7:2] == 6'h34);
            set = '0;
            for (int n = 0; n < 4; n++) begin
                if (m_d2[n] == m_prev[n]) begin
                    if (m_run[n] <= D) m_run[n]++;
                    if (m_run[n] > D && m_stable[n] != m_d2[n]) begin
                        m_stable[n] = m_d2[n];
                        set[n] = 1'b1;
                    end
                end else begin
                    m_prev[n] = m_d2[n];
                    m_run[n]  = 1;
                end
                m_d2[n] = m_d1[n];
                m_d1[n] = drv[n];
            end
            m_irq = |m_chg;
            m_chg = (m_chg & ~{4{clr}}) | set;
            if (re) m_rd = sel;
        end
    endtask

    task automatic tick(input logic re, input logic [31:0] a, input string tag);
        @(negedge io_clk);
        read_io_enable = re;
        addr           = a;
        @(posedge io_clk);
        model_edge(reset, re, a);
        #1;
        check32({tag, "_rd"}, io_read_data, m_rd);
        check32({tag, "_irq"}, {31'b0, io_irq}, {31'b0, m_irq});
        $display("cyc %s rst=%0b re=%0b addr=%h rd=%h irq=%0b", tag, reset, re, a, io_read_data, io_irq);
    endtask

    initial begin
        logic [31:0] bases [8];
        logic [31:0] a;
        logic [31:0] r;
        int          p;

        bases = '{32'hC0, 32'hC4, 32'hC8, 32'hCC, 32'hD0, 32'h90, 32'hD8, 32'h00};
        for (int n = 0; n < 4; n++) drv[n] = '0;
        read_io_enable = 1'b0;
        addr           = '0;

        // Reset with a value already on port 0; it is accepted after release.
        drv[0] = 32'hA5A5_0000;
        reset  = 1'b1;
        tick(0, 0, "rst0");
        tick(0, 0, "rst1");
        check32("reset_rd", io_read_data, 32'h0);
        check32("reset_irq", {31'b0, io_irq}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick(0, 0, "t1_wait");
        check32("t1_irq", {31'b0, io_irq}, 32'h1);
        tick(1, 32'hC0, "t1_rd_c0");
        check32("t1_port0", io_read_data, 32'hA5A5_0000);

        // Clear flags, then step port 1 and probe the acceptance edge.
        tick(1, 32'hD0, "t2_clr");
        check32("t2_status", io_read_data, 32'h1);
        tick(0, 0, "t2_idle");
        drv[1] = 32'h0000_00FF;
        for (int i = 0; i < 5; i++) tick(0, 0, "t2_e");
        tick(1, 32'hC4, "t2_e5");
        check32("t2_e5_rd", io_read_data, 32'h0);
        tick(1, 32'hC4, "t2_e6");
        check32("t2_e6_rd", io_read_data, 32'h0);
        check32("t2_e6_irq", {31'b0, io_irq}, 32'h0);
        tick(1, 32'hC4, "t2_e7");
        check32("t2_e7_rd", io_read_data, 32'h0000_00FF);
        check32("t2_e7_irq", {31'b0, io_irq}, 32'h1);

        // Short pulse on port 2 must be rejected.
        tick(1, 32'hD0, "t3_clr");
        tick(0, 0, "t3_idle");
        drv[2] = 32'h1;
        for (int i = 0; i < 3; i++) tick(0, 0, "t3_pulse");
        drv[2] = 32'h0;
        for (int i = 0; i < 10; i++) tick(0, 0, "t3_wait");
        check32("t3_irq", {31'b0, io_irq}, 32'h0);
        tick(1, 32'hC8, "t3_rd_c8");
        check32("t3_port2", io_read_data, 32'h0);
        tick(1, 32'hD0, "t3_rd_d0");
        check32("t3_status", io_read_data, 32'h0);

        // Two flags set, then read-to-clear and irq fall one edge later.
        drv[0] = 32'h1234_5678;
        drv[1] = 32'h0000_0055;
        for (int i = 0; i < 8; i++) tick(0, 0, "t4_wait");
        tick(1, 32'hD0, "t4_clr");
        check32("t4_status", io_read_data, 32'h3);
        check32("t4_irq_hold", {31'b0, io_irq}, 32'h1);
        tick(0, 0, "t4_idle");
        check32("t4_irq_fall", {31'b0, io_irq}, 32'h0);
        tick(1, 32'hD0, "t4_clr2");
        check32("t4_status2", io_read_data, 32'h0);

        // Port 3 accepted on the same edge as a clearing read: set wins.
        drv[0] = 32'h0F0F_0F0F;
        for (int i = 0; i < 8; i++) tick(0, 0, "t5_wait");
        drv[3] = 32'hCAFE_0003;
        for (int i = 0; i < 6; i++) tick(0, 0, "t5_e");
        tick(1, 32'hD0, "t5_e6");
        check32("t5_status", io_read_data, 32'h1);
        tick(1, 32'hD0, "t5_after");
        check32("t5_status2", io_read_data, 32'h8);

        // Unmapped offsets, then reset in the middle of a debounce.
        tick(1, 32'h90, "t6_rd_90");
        check32("t6_rd_90v", io_read_data, 32'h0);
        tick(1, 32'hD8, "t6_rd_d8");
        check32("t6_rd_d8v", io_read_data, 32'h0);
        tick(1, 32'hCC, "t6_rd_cc");
        drv[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) tick(0, 0, "t6_mid");
        reset = 1'b1;
        tick(1, 32'hCC, "t6_rst");
        check32("t6_rst_rd", io_read_data, 32'h0);
        check32("t6_rst_irq", {31'b0, io_irq}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick(0, 0, "t6_wait");
        tick(1, 32'hD0, "t6_status");
        check32("t6_reaccept", io_read_data, 32'hF);

        // Random traffic: port changes, glitches, reads with junk address bits.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                p = $urandom_range(0, 3);
                drv[p] = (r[0]) ? $urandom : (r[1] ? 32'h0 : drv[p] ^ (32'h1 << r[6:2]));
            end
            reset = ($urandom_range(0, 299) == 0);
            a = bases[$urandom_range(0, 7)];
            a = {$urandom_range(0, 255), 24'h0} | {16'h0, 8'h0, a[7:2], r[9:8]};
            tick(($urandom_range(0, 2) == 0), a, "rnd");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
